// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the parametrised UART transmitter.
//   - txState_t : frame sequencing states
//   - PARITY_*  : encodings for the PARITY_MODE parameter
// Optional feature macro used elsewhere in this slice: UART_TX_BREAK_EN
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
//   Word-side handshake and serial-side status bundle of the UART transmitter.
//   Signals:
//     tx_valid    master->slave  tx_data_in holds a word to send
//     tx_ready    slave->master  transmitter can accept a word this cycle
//     tx_data_in  master->slave  parallel word, LSB transmitted first
//     tx_break    master->slave  line-break request (only with UART_TX_BREAK_EN)
//     tx_data_out slave->master  serial line, idles high
//     done        slave->master  one-cycle pulse at frame completion
//     busy        slave->master  high while a frame is on the line
//   Macro: UART_TX_BREAK_EN adds tx_break.
interface uart_tx_param_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data_in;
`ifdef UART_TX_BREAK_EN
  logic                  tx_break;
`endif
  logic                  tx_data_out;
  logic                  done;
  logic                  busy;

`ifdef UART_TX_BREAK_EN
  modport master (
    output tx_valid, tx_data_in, tx_break,
    input  tx_ready, tx_data_out, done, busy
  );

  modport slave (
    input  tx_valid, tx_data_in, tx_break,
    output tx_ready, tx_data_out, done, busy
  );
`else
  modport master (
    output tx_valid, tx_data_in,
    input  tx_ready, tx_data_out, done, busy
  );

  modport slave (
    input  tx_valid, tx_data_in,
    output tx_ready, tx_data_out, done, busy
  );
`endif

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period timer for the UART transmitter. Counts tx_clk cycles and flags
//   the last cycle of every bit period.
//   Ports:
//     i_clk      clock
//     i_rst      synchronous active-high reset
//     i_clear    holds the counter at zero (phase alignment at frame start)
//     o_bitTick  high during count CLKS_PER_BIT-1, i.e. the last cycle of a bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bitTick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // The counter wraps only through the explicit compare against LAST_COUNT,
  // so non-power-of-two periods never rely on natural overflow. While the
  // transmitter idles it is held at zero so every frame starts on a fresh
  // bit period.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST_COUNT) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bitTick = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB first,
//   optional parity bit, STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
//   Ports:
//     i_tx_clk  single clock
//     i_rst     synchronous reset, active-high
//     bus       uart_tx_param_if slave modport (valid/ready word input,
//               serial line, done pulse, busy flag, optional break request)
//   Parameters: DATA_WIDTH (5..9), CLKS_PER_BIT (>=2), PARITY_MODE
//               (0 none, 1 even, 2 odd), STOP_BITS (1..2).
//   Macro: UART_TX_BREAK_EN enables the line-break request in IDLE.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_tx_clk,
  input  logic           i_rst,
  uart_tx_param_if.slave bus
);

  // Reject configurations the datapath was not sized for.
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : gBadDataWidth
    $error("uart_tx_param: DATA_WIDTH must be within 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
      PARITY_MODE != PARITY_ODD) begin : gBadParityMode
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  txState_t              r_state;
  txState_t              w_nextState;
  logic [DATA_WIDTH-1:0] r_shiftReg;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic                  r_parityBit;
  logic                  w_nextParity;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [BIT_CNT_W-1:0]  w_nextBitCnt;
  logic                  r_line;
  logic                  w_nextLine;
  logic                  r_busy;
  logic                  w_nextBusy;
  logic                  r_done;
  logic                  w_nextDone;
  logic                  r_breakActive;
  logic                  w_nextBreak;
  logic                  w_breakReq;
  logic                  w_bitTick;
  logic                  w_accept;

`ifdef UART_TX_BREAK_EN
  assign w_breakReq = bus.tx_break;
`else
  assign w_breakReq = 1'b0;
`endif

  // Bit timing restarts from zero whenever the FSM sits in IDLE, so the first
  // START cycle after a transfer is always phase 0.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudGen (
    .i_clk     (i_tx_clk),
    .i_rst     (i_rst),
    .i_clear   (r_state == IDLE),
    .o_bitTick (w_bitTick)
  );

  assign bus.tx_ready = (r_state == IDLE) & ~i_rst & ~r_breakActive;
  assign w_accept     = bus.tx_valid & bus.tx_ready;

  // Next-state logic. The serial line, busy and done are registered, so their
  // next values are derived from the state being entered rather than the
  // current one; that keeps the line glitch-free and lines START up with the
  // cycle right after the transfer edge. The break request is only looked at
  // while idling and not accepting a word, so a request raised mid-frame waits
  // until the frame has completed.
  always_comb begin
    w_nextState  = r_state;
    w_nextShift  = r_shiftReg;
    w_nextParity = r_parityBit;
    w_nextBitCnt = r_bitCnt;
    w_nextDone   = 1'b0;
    w_nextBreak  = r_breakActive;
    w_nextLine   = 1'b1;
    w_nextBusy   = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextShift  = bus.tx_data_in;
          w_nextParity = (PARITY_MODE == PARITY_ODD) ? ~^bus.tx_data_in
                                                     :  ^bus.tx_data_in;
          w_nextBitCnt = '0;
          w_nextBreak  = 1'b0;
          w_nextState  = START;
        end else begin
          w_nextBreak  = w_breakReq;
        end
      end
      START: begin
        if (w_bitTick) begin
          w_nextBitCnt = '0;
          w_nextState  = DATA;
        end
      end
      DATA: begin
        if (w_bitTick) begin
          w_nextShift = r_shiftReg >> 1;
          if (r_bitCnt == LAST_DATA_BIT) begin
            w_nextBitCnt = '0;
            w_nextState  = HAS_PARITY ? PARITY : STOP;
          end else begin
            w_nextBitCnt = r_bitCnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bitTick) begin
          w_nextBitCnt = '0;
          w_nextState  = STOP;
        end
      end
      STOP: begin
        if (w_bitTick) begin
          if (r_bitCnt == LAST_STOP_BIT) begin
            w_nextBitCnt = '0;
            w_nextDone   = 1'b1;
            w_nextState  = IDLE;
          end else begin
            w_nextBitCnt = r_bitCnt + 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    case (w_nextState)
      IDLE: begin
        w_nextLine = ~w_nextBreak;
        w_nextBusy = 1'b0;
      end
      START:   w_nextLine = 1'b0;
      DATA:    w_nextLine = w_nextShift[0];
      PARITY:  w_nextLine = w_nextParity;
      STOP:    w_nextLine = 1'b1;
      default: begin
        w_nextLine = 1'b1;
        w_nextBusy = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset aborts any frame in flight: the line
  // returns high on the following cycle and no done pulse is produced.
  always_ff @(posedge i_tx_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_shiftReg    <= '0;
      r_parityBit   <= 1'b0;
      r_bitCnt      <= '0;
      r_line        <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_breakActive <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_shiftReg    <= w_nextShift;
      r_parityBit   <= w_nextParity;
      r_bitCnt      <= w_nextBitCnt;
      r_line        <= w_nextLine;
      r_busy        <= w_nextBusy;
      r_done        <= w_nextDone;
      r_breakActive <= w_nextBreak;
    end
  end

  assign bus.tx_data_out = r_line;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
//   Drives three transmitter instances (even parity/1 stop, odd parity/2 stop,
//   no parity/1 stop; 8 data bits, 4 clocks per bit) with randomized words,
//   valid patterns, resets and (with UART_TX_BREAK_EN) break requests, and
//   compares line, busy, done and tx_ready every cycle against a frame-level
//   reference model.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int LANES = 3;
  localparam int NCYC  = 3000;

  function automatic int laneParity(input int lane);
    case (lane)
      0:       return PARITY_EVEN;
      1:       return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

  function automatic int laneStops(input int lane);
    return (lane == 1) ? 2 : 1;
  endfunction

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic [LANES-1:0] txValid;
  logic [LANES-1:0] txReady;
  logic [LANES-1:0] txLine;
  logic [LANES-1:0] txDone;
  logic [LANES-1:0] txBusy;
  logic [DW-1:0]    txData [LANES];
`ifdef UART_TX_BREAK_EN
  logic [LANES-1:0] txBreak;
`endif

  for (genvar g = 0; g < LANES; g++) begin : gDut
    uart_tx_param_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.tx_valid   = txValid[g];
    assign bus.tx_data_in = txData[g];
`ifdef UART_TX_BREAK_EN
    assign bus.tx_break   = txBreak[g];
`endif
    assign txReady[g] = bus.tx_ready;
    assign txLine[g]  = bus.tx_data_out;
    assign txDone[g]  = bus.done;
    assign txBusy[g]  = bus.busy;

    uart_tx_param #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .PARITY_MODE  (laneParity(g)),
      .STOP_BITS    (laneStops(g))
    ) dut (
      .i_tx_clk (clock),
      .i_rst    (reset),
      .bus      (bus.slave)
    );
  end

  int checkCount = 0;
  int errorCount = 0;

  int   pos       [LANES];
  int   frameLen  [LANES];
  logic expDone   [LANES];
  logic breakAct  [LANES];
  logic frameBits [LANES][16];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic buildFrame(input int lane, input logic [DW-1:0] data);
    int n;
    int ones;
    n = 0;
    frameBits[lane][n] = 1'b0;
    n++;
    for (int j = 0; j < DW; j++) begin
      frameBits[lane][n] = data[j];
      n++;
    end
    ones = $countones(data);
    if (laneParity(lane) == PARITY_EVEN) begin
      frameBits[lane][n] = (ones % 2 == 1);
      n++;
    end else if (laneParity(lane) == PARITY_ODD) begin
      frameBits[lane][n] = (ones % 2 == 0);
      n++;
    end
    for (int s = 0; s < laneStops(lane); s++) begin
      frameBits[lane][n] = 1'b1;
      n++;
    end
    frameLen[lane] = n * CPB;
    pos[lane]      = 0;
  endtask

  task automatic advanceModel(input int lane, input logic rstIn, input logic valid,
                              input logic [DW-1:0] data, input logic brk);
    if (rstIn) begin
      pos[lane]      = -1;
      expDone[lane]  = 1'b0;
      breakAct[lane] = 1'b0;
    end else begin
      expDone[lane] = 1'b0;
      if (pos[lane] >= 0) begin
        pos[lane]++;
        if (pos[lane] == frameLen[lane]) begin
          pos[lane]     = -1;
          expDone[lane] = 1'b1;
        end
      end else if (valid && !breakAct[lane]) begin
        buildFrame(lane, data);
      end else begin
        breakAct[lane] = brk;
      end
    end
  endtask

  task automatic checkLanes(input int cyc);
    logic expLine;
    logic expBusy;
    logic expReady;
    for (int i = 0; i < LANES; i++) begin
      expBusy  = (pos[i] >= 0);
      expLine  = (pos[i] >= 0) ? frameBits[i][pos[i] / CPB] : !breakAct[i];
      expReady = (pos[i] < 0) && !breakAct[i] && !reset;
      checkOutput($sformatf("cyc%0d lane%0d line", cyc, i), 32'(txLine[i]), 32'(expLine));
      checkOutput($sformatf("cyc%0d lane%0d busy", cyc, i), 32'(txBusy[i]), 32'(expBusy));
      checkOutput($sformatf("cyc%0d lane%0d done", cyc, i), 32'(txDone[i]), 32'(expDone[i]));
      checkOutput($sformatf("cyc%0d lane%0d ready", cyc, i), 32'(txReady[i]), 32'(expReady));
    end
  endtask

  // Phase A: valid held high (back-to-back frames, 0xA5 first), data churning.
  // Phase B: sparse random valid, occasional reset and break activity.
  // Phase C: valid held high then a forced reset in the middle of the frames.
  task automatic applyStimulus(input int cyc);
    logic          valid;
    logic [DW-1:0] data;
    logic          brk;
    if (cyc < 2) begin
      reset = 1'b1;
    end else if (cyc >= 2500 && cyc < 2600) begin
      reset = (cyc == 2530);
    end else if (cyc >= 300) begin
      reset = ($urandom_range(0, 299) == 0);
    end else begin
      reset = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (cyc < 300 || (cyc >= 2500 && cyc < 2600)) begin
        valid = 1'b1;
      end else begin
        valid = ($urandom_range(0, 3) == 0);
      end
      data = (cyc < 20) ? 8'hA5 : DW'($urandom);
      brk  = 1'b0;
`ifdef UART_TX_BREAK_EN
      if (cyc >= 300 && cyc < 2500 && $urandom_range(0, 39) == 0) begin
        txBreak[i] = ~txBreak[i];
      end else if (cyc >= 2500) begin
        txBreak[i] = 1'b0;
      end
      brk = txBreak[i];
`endif
      txValid[i] = valid;
      txData[i]  = data;
      advanceModel(i, reset, valid, data, brk);
    end
  endtask

  initial begin
    txValid = '0;
`ifdef UART_TX_BREAK_EN
    txBreak = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      txData[i]   = '0;
      pos[i]      = -1;
      frameLen[i] = 0;
      expDone[i]  = 1'b0;
      breakAct[i] = 1'b0;
      for (int b = 0; b < 16; b++) begin
        frameBits[i][b] = 1'b1;
      end
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      checkLanes(cyc);
      applyStimulus(cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
